// File: rtl/spike_window_packer.sv
// Packs a serial per-timestep spike stream into T_WINDOW-bit temporal patterns
// (bit i = spike at timestep i). A fill register and an output register form a
// two-deep buffer so the downstream matcher can stall without losing samples.
module spike_window_packer #(
  parameter int unsigned T_WINDOW = 16,
  parameter int unsigned CNT_W    = $clog2(T_WINDOW),
  parameter int unsigned WCNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spike_in,
  input  logic                spike_valid,
  output logic                spike_ready,
  input  logic                flush,
  output logic [T_WINDOW-1:0] pattern_out,
  output logic                pattern_valid,
  input  logic                pattern_ready,
  output logic [CNT_W-1:0]    fill_idx,
  output logic [WCNT_W-1:0]   win_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(T_WINDOW - 1);

  logic [T_WINDOW-1:0] fill_q, fill_d;
  logic                full_q, full_d;
  logic [CNT_W-1:0]    idx_d;
  logic [T_WINDOW-1:0] pat_d;
  logic                pv_d;
  logic [WCNT_W-1:0]   wc_d;

  logic                slot_free;
  logic                accept;
  logic                complete;
  logic [T_WINDOW-1:0] fill_with;

  // Ready depends only on the registered full flag, never on downstream ready.
  assign spike_ready = !full_q;

  // Next-state: sample insertion, window completion, output-slot hand-off.
  always_comb begin
    fill_d    = fill_q;
    full_d    = full_q;
    idx_d     = fill_idx;
    pat_d     = pattern_out;
    pv_d      = pattern_valid;
    wc_d      = win_count;

    slot_free = !pattern_valid || pattern_ready;
    accept    = spike_valid && !full_q;
    fill_with = fill_q;
    if (accept && spike_in) begin
      fill_with = fill_q | (T_WINDOW'(1) << fill_idx);
    end
    // A same-cycle sample counts towards the window a flush closes.
    complete  = !full_q &&
                ((accept && (fill_idx == LAST_IDX)) ||
                 (flush && ((fill_idx != '0) || accept)));

    if (pattern_valid && pattern_ready) begin
      pv_d = 1'b0;
    end

    if (full_q) begin
      // Held window moves out as soon as the output slot frees.
      if (slot_free) begin
        pat_d  = fill_q;
        pv_d   = 1'b1;
        fill_d = '0;
        idx_d  = '0;
        full_d = 1'b0;
        wc_d   = win_count + WCNT_W'(1);
      end
    end else if (complete) begin
      if (slot_free) begin
        pat_d  = fill_with;
        pv_d   = 1'b1;
        fill_d = '0;
        idx_d  = '0;
        wc_d   = win_count + WCNT_W'(1);
      end else begin
        // Upper bits are already zero, which provides the flush padding.
        fill_d = fill_with;
        full_d = 1'b1;
      end
    end else if (accept) begin
      fill_d = fill_with;
      idx_d  = fill_idx + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q        <= '0;
      full_q        <= 1'b0;
      fill_idx      <= '0;
      pattern_out   <= '0;
      pattern_valid <= 1'b0;
      win_count     <= '0;
    end else begin
      fill_q        <= fill_d;
      full_q        <= full_d;
      fill_idx      <= idx_d;
      pattern_out   <= pat_d;
      pattern_valid <= pv_d;
      win_count     <= wc_d;
    end
  end

endmodule

// File: tb/tb_spike_window_packer.sv
// Self-checking bench for spike_window_packer: directed scenarios plus a random
// stream compared cycle by cycle against a queue-based window model.
module tb_spike_window_packer;

  localparam int unsigned T = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spike_in = 1'b0;
  logic          spike_valid = 1'b0;
  logic          spike_ready;
  logic          flush = 1'b0;
  logic [T-1:0]  pattern_out;
  logic          pattern_valid;
  logic          pattern_ready = 1'b0;
  logic [3:0]    fill_idx;
  logic [15:0]   win_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: samples of the open window, a held window, the output slot, a count.
  bit           m_cur[$];
  bit           m_held_v;
  logic [T-1:0] m_held;
  bit           m_out_v;
  logic [T-1:0] m_out;
  logic [15:0]  m_cnt;

  spike_window_packer #(.T_WINDOW(T), .CNT_W(4), .WCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .spike_valid(spike_valid),
    .spike_ready(spike_ready), .flush(flush), .pattern_out(pattern_out),
    .pattern_valid(pattern_valid), .pattern_ready(pattern_ready),
    .fill_idx(fill_idx), .win_count(win_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [T-1:0] pack_cur();
    logic [T-1:0] w = '0;
    for (int i = 0; i < m_cur.size(); i++) w[i] = m_cur[i];
    return w;
  endfunction

  task automatic model_reset();
    m_cur.delete();
    m_held_v = 0; m_held = '0;
    m_out_v = 0;  m_out = '0;
    m_cnt = '0;
  endtask

  // One clock edge of the window-packing rules.
  task automatic model_step(input bit sv, input bit s, input bit fl, input bit pr);
    bit acc, slot_free, consumed, complete;
    logic [T-1:0] w;
    acc       = sv && !m_held_v;
    slot_free = !m_out_v || pr;
    consumed  = m_out_v && pr;
    if (m_held_v) begin
      if (slot_free) begin
        m_out = m_held; m_out_v = 1; m_held_v = 0; m_cnt++;
      end
    end else begin
      if (acc) m_cur.push_back(s);
      complete = (m_cur.size() == T) || (fl && m_cur.size() > 0);
      if (complete) begin
        w = pack_cur();
        m_cur.delete();
        if (slot_free) begin
          m_out = w; m_out_v = 1; m_cnt++;
        end else begin
          m_held = w; m_held_v = 1;
        end
      end else if (consumed) begin
        m_out_v = 0;
      end
    end
  endtask

  // Drive one cycle of inputs; returns #1 after the active edge.
  task automatic cycle(input bit sv, input bit s, input bit fl, input bit pr);
    spike_valid = sv; spike_in = s; flush = fl; pattern_ready = pr;
    @(posedge clk);
    model_step(sv, s, fl, pr);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 0; spike_valid = 0; spike_in = 0; flush = 0; pattern_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (pattern_valid !== 1'b0 || pattern_out !== '0 || fill_idx !== '0 ||
        win_count !== '0 || spike_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset: pv=%b po=%h idx=%0d wc=%0d rdy=%b, want 0 0000 0 0 1",
               pattern_valid, pattern_out, fill_idx, win_count, spike_ready);
    end
  endtask

  task automatic test_full_window();
    for (int i = 0; i < 16; i++) begin
      cycle(1, (i % 2) == 0, 0, 1);
      if (i == 14) begin
        n_checks++;
        if (pattern_valid !== 1'b0 || fill_idx !== 4'd15) begin
          n_errors++;
          $display("FAIL full_window_pre: pv=%b idx=%0d, want 0 15", pattern_valid, fill_idx);
        end
      end
    end
    n_checks++;
    if (pattern_valid !== 1'b1 || pattern_out !== 16'h5555 || win_count !== 16'd1 ||
        fill_idx !== 4'd0) begin
      n_errors++;
      $display("FAIL full_window: pv=%b po=%h wc=%0d idx=%0d, want 1 5555 1 0",
               pattern_valid, pattern_out, win_count, fill_idx);
    end
  endtask

  task automatic test_flush();
    logic [15:0] wc0;
    cycle(0, 0, 0, 1);
    wc0 = win_count;
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1);
    n_checks++;
    if (fill_idx !== 4'd5 || pattern_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_pre: idx=%0d pv=%b, want 5 0", fill_idx, pattern_valid);
    end
    cycle(0, 0, 1, 1);
    n_checks++;
    if (pattern_valid !== 1'b1 || pattern_out !== 16'h001F || fill_idx !== 4'd0 ||
        win_count !== wc0 + 16'd1) begin
      n_errors++;
      $display("FAIL flush: pv=%b po=%h idx=%0d wc=%0d, want 1 001f 0 %0d",
               pattern_valid, pattern_out, fill_idx, win_count, wc0 + 16'd1);
    end
    cycle(0, 0, 1, 1);
    n_checks++;
    if (pattern_valid !== 1'b0 || win_count !== wc0 + 16'd1 || fill_idx !== 4'd0) begin
      n_errors++;
      $display("FAIL flush_idle: pv=%b wc=%0d idx=%0d, want 0 %0d 0",
               pattern_valid, win_count, fill_idx, wc0 + 16'd1);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0);
    for (int i = 0; i < 16; i++) cycle(1, (i % 8) >= 4, 0, 0);
    n_checks++;
    if (spike_ready !== 1'b0 || pattern_valid !== 1'b1 || pattern_out !== 16'hFFFF ||
        win_count !== 16'd1) begin
      n_errors++;
      $display("FAIL stall_full: rdy=%b pv=%b po=%h wc=%0d, want 0 1 ffff 1",
               spike_ready, pattern_valid, pattern_out, win_count);
    end
    // Samples offered while full must be refused and the output must not move.
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
    n_checks++;
    if (spike_ready !== 1'b0 || pattern_out !== 16'hFFFF || pattern_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_hold: rdy=%b pv=%b po=%h, want 0 1 ffff",
               spike_ready, pattern_valid, pattern_out);
    end
    cycle(0, 0, 0, 1);
    n_checks++;
    if (pattern_valid !== 1'b1 || pattern_out !== 16'hF0F0 || win_count !== 16'd2 ||
        spike_ready !== 1'b1 || fill_idx !== 4'd0) begin
      n_errors++;
      $display("FAIL stall_release: pv=%b po=%h wc=%0d rdy=%b idx=%0d, want 1 f0f0 2 1 0",
               pattern_valid, pattern_out, win_count, spike_ready, fill_idx);
    end
    cycle(0, 0, 0, 1);
    n_checks++;
    if (pattern_valid !== 1'b0 || win_count !== 16'd2) begin
      n_errors++;
      $display("FAIL stall_drain: pv=%b wc=%0d, want 0 2", pattern_valid, win_count);
    end
  endtask

  task automatic test_flush_with_sample();
    cycle(1, 1, 0, 1);
    cycle(1, 1, 0, 1);
    cycle(1, 1, 1, 1);
    n_checks++;
    if (pattern_valid !== 1'b1 || pattern_out !== 16'h0007 || fill_idx !== 4'd0) begin
      n_errors++;
      $display("FAIL flush_with_sample: pv=%b po=%h idx=%0d, want 1 0007 0",
               pattern_valid, pattern_out, fill_idx);
    end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_window();
    logic [15:0] fresh;
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(1, 1, 0, 0);
    n_checks++;
    if (fill_idx !== 4'd9 || pattern_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_pre: idx=%0d pv=%b, want 9 1", fill_idx, pattern_valid);
    end
    rst_n = 0;
    #2;
    n_checks++;
    if (pattern_valid !== 1'b0 || pattern_out !== '0 || fill_idx !== '0 ||
        win_count !== '0 || spike_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_async: pv=%b po=%h idx=%0d wc=%0d rdy=%b, want 0 0000 0 0 1",
               pattern_valid, pattern_out, fill_idx, win_count, spike_ready);
    end
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    fresh = 16'($urandom);
    for (int i = 0; i < 16; i++) begin
      cycle(1, fresh[i], 0, 1);
      if (i < 15 && pattern_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_stale: pv=%b at sample %0d, want 0", pattern_valid, i);
      end
    end
    n_checks++;
    if (pattern_valid !== 1'b1 || pattern_out !== fresh || win_count !== 16'd1) begin
      n_errors++;
      $display("FAIL midreset_fresh: pv=%b po=%h wc=%0d, want 1 %h 1",
               pattern_valid, pattern_out, win_count, fresh);
    end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_random_stream();
    int windows = 0;
    bit sv, s, fl, pr;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      sv = $urandom_range(0, 3) != 0;
      s  = $urandom_range(0, 1) == 1;
      fl = $urandom_range(0, 15) == 0;
      pr = $urandom_range(0, 2) != 0;
      n_checks++;
      if (spike_ready !== !m_held_v) begin
        n_errors++;
        $display("FAIL rand_ready c=%0d: rdy=%b, want %b", c, spike_ready, !m_held_v);
      end
      cycle(sv, s, fl, pr);
      n_checks++;
      if (pattern_valid !== m_out_v || (m_out_v && pattern_out !== m_out) ||
          win_count !== m_cnt) begin
        n_errors++;
        $display("FAIL rand_out c=%0d: pv=%b po=%h wc=%0d, want %b %h %0d",
                 c, pattern_valid, pattern_out, win_count, m_out_v, m_out, m_cnt);
      end
      if (!m_held_v) begin
        n_checks++;
        if (fill_idx !== 4'(m_cur.size())) begin
          n_errors++;
          $display("FAIL rand_idx c=%0d: idx=%0d, want %0d", c, fill_idx, m_cur.size());
        end
      end
      windows = int'(m_cnt);
    end
    n_checks++;
    if (windows < 40) begin
      n_errors++;
      $display("FAIL rand_activity: windows=%0d, want >= 40", windows);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_window();
    test_flush();
    test_stall();
    test_flush_with_sample();
    test_reset_mid_window();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
